uart_rx_cfg: RTL and testbench
==============================

// Module: uart_rx_cfg
// PURPOSE
//  Parametrised UART receiver, next generation of the team's fixed 8-bit even-parity receiver.
//  Oversamples serial_in, validates start/mid-bit/stop timing, assembles 5..9-bit words (LSB first).
//  Checks none/even/odd parity and 1 or 2 stop bits; flags parity, framing, overrun and break.
//  Delivers words over a valid/ready handshake to the downstream consumer (FIFO or register file).
// PARAMETERS
//  CLKS_PER_BIT  16  clk cycles per bit period; legal >= 4
//  DATA_BITS     8   data bits per frame; legal 5..9
//  PARITY        1   0 = none, 1 = even, 2 = odd
//  STOP_BITS     1   1 or 2
//  SYNC_STAGES   2   input synchroniser depth; legal >= 2
// PORTS
//  clk          in   1          system clock; all logic on posedge
//  reset        in   1          synchronous, active-high
//  serial_in    in   1          asynchronous RX line, idle high
//  data_out     out  DATA_BITS  received word, stable while data_valid=1
//  data_valid   out  1          word available; held until accepted
//  data_ready   in   1          consumer accepts when data_valid && data_ready
//  parity_err   out  1          parity mismatch for the word in data_out; qualified by data_valid
//  frame_err    out  1          stop bit(s) sampled 0 for the word in data_out; qualified by data_valid
//  overrun_err  out  1          1-cycle pulse: completed frame dropped because the output was full
//  break_det    out  1          1-cycle pulse: break condition detected
//  busy         out  1          1 when state != IDLE
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, armed=0, counters 0. Reset mid-frame aborts the frame; nothing is delivered.
//  Line: rx = serial_in after SYNC_STAGES flops. armed sets once rx=1 is sampled in IDLE.
//  States:
//   IDLE:   armed && rx=0 -> START, cnt=0.
//   START:  at cnt=CLKS_PER_BIT/2-1, sample rx. rx=1 -> IDLE (glitch, no output). Else cnt=0 -> DATA.
//   DATA:   sample at cnt=CLKS_PER_BIT-1, shift in LSB first. After DATA_BITS samples -> PARITY (PARITY!=0) or STOP.
//   PARITY: sample p. Even expects p=^word; odd expects p=~^word.
//   STOP:   sample STOP_BITS bits; any 0 sets frame_err; after the last sample -> IDLE with armed=0.
//  All samples are taken mid-bit. cnt width $clog2(CLKS_PER_BIT); bit index width $clog2(DATA_BITS+1).
//  Delivery:
//   data_out/parity_err/frame_err/data_valid load 1 cycle after the final stop sample.
//   Latency from the rx falling edge: CLKS_PER_BIT/2 + (DATA_BITS+(PARITY!=0)+STOP_BITS)*CLKS_PER_BIT + 1 cycles.
//   data_valid is cleared on the cycle data_valid && data_ready is seen.
//  Overrun: frame completes while data_valid=1 and data_ready=0 -> old word kept, new word dropped, overrun_err pulses.
//   Completion in the same cycle as acceptance -> new word loads, no overrun.
//  Break: all data bits, parity bit (if present) and stop bits sampled 0 -> break_det pulses.
//   No word is delivered and frame_err is not raised. Because armed=0, no new start is taken until rx returns high.
//  Errored frames (parity/frame) are still delivered; the error flags travel with the word.
// STRUCTURE
//  Package uart_pkg: state encoding (IDLE/START/DATA/PARITY/STOP) and parity-mode constants PAR_NONE/PAR_EVEN/PAR_ODD.
//  Sub-module uart_sync_in: SYNC_STAGES-deep synchroniser with reset value 1.
//  The FSM, counters, shift register and output register stay in this module.
// TESTING (CLKS_PER_BIT=16, DATA_BITS=8, PARITY=1, STOP_BITS=1 unless stated)
//  1 Frame 0xA5, p=0, stop=1; data_ready=0 for 50 cycles -> data_out=0xA5, data_valid held, no error flags;
//    ready=1 -> data_valid drops next cycle.
//  2 Frame 0x01 with p=0 (wrong) -> data_valid with data_out=0x01 and parity_err=1; frame_err=0.
//  3 rx low for 5 cycles then high -> no DATA entry, busy back to 0, data_valid stays 0.
//  4 Frame 0x3C with stop=0 -> frame_err=1.
//    Then rx low for 12 bit times -> exactly one break_det pulse, no data_valid; next frame 0x55 is received after rx idles high.
//  5 Back-to-back frames 0x11 then 0x22 with data_ready=0 -> data_out stays 0x11, one overrun_err pulse.
//    Repeat with ready pulsed on the completion cycle -> 0x22 loads, no overrun.
//  6 reset during data bit 3 -> all outputs 0 next cycle; following frame 0x5A is received cleanly.
//    Repeat scenario 1 with PARITY=0, STOP_BITS=2, DATA_BITS=7 and word 0x7F.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART receiver: FSM state encoding,
// parity-mode constants and the expected-parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Parity bit the transmitter should have sent, given the XOR of the data bits.
  function automatic logic parity_expected(input int mode, input logic data_xor);
    return (mode == PAR_ODD) ? ~data_xor : data_xor;
  endfunction

endpackage

// File: rtl/uart_sync_in.sv
// Multi-flop synchroniser for the asynchronous RX line. Resets to 1 so the
// line reads as idle until real samples propagate through.
module uart_sync_in #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] stages;

  // Shift the raw line through the synchroniser chain.
  always_ff @(posedge clk) begin
    if (reset) stages <= '1;
    else       stages <= {stages[SYNC_STAGES-2:0], d};
  end

  assign q = stages[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_cfg.sv
// Parametrised oversampling UART receiver. Frames of DATA_BITS data bits
// (LSB first), optional even/odd parity and 1 or 2 stop bits are assembled
// and offered downstream on data_valid/data_ready.
//
// Handshake: data_valid rises with a new word and stays high, with data_out,
// parity_err and frame_err stable, until a cycle where data_valid && data_ready
// is seen at posedge clk; that cycle is the transfer. data_ready may be driven
// combinationally from anything except data_valid-dependent loops in the consumer.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 1,
  parameter int STOP_BITS    = 1,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 serial_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 break_det,
  output logic                 busy,
  output logic [2:0]           state_dbg
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);
  localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

  uart_state_e          state;
  logic                 rx;
  logic                 armed;
  logic [CNT_W-1:0]     cnt;
  logic [BIT_W-1:0]     bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 zero_acc;  // every sampled bit of this frame so far was 0
  logic                 par_acc;   // parity mismatch seen
  logic                 frm_acc;   // a stop bit sampled 0
  logic                 done_q;    // frame finished last cycle; deliver now
  logic                 pend_brk;
  logic                 pend_frm;

  uart_sync_in #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (serial_in),
    .q     (rx)
  );

  // Frame-sampling FSM plus the output register and handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      armed       <= 1'b0;
      cnt         <= '0;
      bit_idx     <= '0;
      stop_idx    <= 1'b0;
      shreg       <= '0;
      zero_acc    <= 1'b0;
      par_acc     <= 1'b0;
      frm_acc     <= 1'b0;
      done_q      <= 1'b0;
      pend_brk    <= 1'b0;
      pend_frm    <= 1'b0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
      break_det   <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      overrun_err <= 1'b0;
      break_det   <= 1'b0;

      case (state)
        ST_IDLE: begin
          cnt <= '0;
          // A start is only taken once the line has been seen idle-high,
          // which keeps a held-low break from retriggering.
          if (rx) armed <= 1'b1;
          else if (armed) state <= ST_START;
        end
        ST_START: begin
          if (cnt == HALF_M1) begin
            cnt <= '0;
            if (rx) begin
              state <= ST_IDLE;
            end else begin
              state    <= ST_DATA;
              bit_idx  <= '0;
              stop_idx <= 1'b0;
              zero_acc <= 1'b1;
              par_acc  <= 1'b0;
              frm_acc  <= 1'b0;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_DATA: begin
          if (cnt == FULL_M1) begin
            cnt      <= '0;
            shreg    <= {rx, shreg[DATA_BITS-1:1]};
            zero_acc <= zero_acc & ~rx;
            bit_idx  <= bit_idx + BIT_W'(1);
            if (bit_idx == LAST_BIT)
              state <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_PARITY: begin
          if (cnt == FULL_M1) begin
            cnt      <= '0;
            par_acc  <= (rx != parity_expected(PARITY, ^shreg));
            zero_acc <= zero_acc & ~rx;
            state    <= ST_STOP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_STOP: begin
          if (cnt == FULL_M1) begin
            cnt      <= '0;
            zero_acc <= zero_acc & ~rx;
            frm_acc  <= frm_acc | ~rx;
            if (stop_idx == LAST_STOP) begin
              state    <= ST_IDLE;
              armed    <= 1'b0;
              done_q   <= 1'b1;
              pend_brk <= zero_acc & ~rx;
              pend_frm <= frm_acc | ~rx;
            end else begin
              stop_idx <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (data_valid && data_ready) data_valid <= 1'b0;

      // Deliver a finished frame; a transfer in the same cycle frees the slot.
      if (done_q) begin
        if (pend_brk) begin
          break_det <= 1'b1;
        end else if (data_valid && !data_ready) begin
          overrun_err <= 1'b1;
        end else begin
          data_out   <= shreg;
          parity_err <= par_acc;
          frame_err  <= pend_frm;
          data_valid <= 1'b1;
        end
      end
    end
  end

  assign busy      = (state != ST_IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: directed scenarios plus random frames, checked by a
// scoreboard fed from a frame-level reference model.
module tb_uart_rx_cfg;

  localparam int CPB  = 16;
  localparam int SYNC = 2;
  localparam int W    = 10;  // {parity_err, frame_err, data[7:0]}
  // Cycles from driving the start bit to data_valid: synchroniser, idle
  // detection, half bit, the remaining bits, output register.
  localparam int LAT1 = SYNC + 1 + CPB / 2 + (8 + 1 + 1) * CPB + 1;
  localparam int FRAME1 = 11 * CPB;

  logic clk = 1'b0;
  logic reset;
  logic serial_in, serial_in2;
  logic data_ready, data_ready2;
  logic [7:0] data_out;
  logic [6:0] data_out2;
  logic data_valid, parity_err, frame_err, overrun_err, break_det, busy;
  logic data_valid2, parity_err2, frame_err2, overrun_err2, break_det2, busy2;
  logic [2:0] state_dbg, state_dbg2;

  logic rand_ready = 1'b0;
  logic ready_cmd  = 1'b0;
  logic [W-1:0] exp_q[$];
  int checks = 0, failures = 0;
  int ovr_cnt = 0, brk_cnt = 0, exp_ovr = 0, exp_brk = 0;

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1),
                .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .reset(reset), .serial_in(serial_in), .data_out(data_out),
    .data_valid(data_valid), .data_ready(data_ready), .parity_err(parity_err),
    .frame_err(frame_err), .overrun_err(overrun_err), .break_det(break_det),
    .busy(busy), .state_dbg(state_dbg));

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2),
                .SYNC_STAGES(SYNC)) dut2 (
    .clk(clk), .reset(reset), .serial_in(serial_in2), .data_out(data_out2),
    .data_valid(data_valid2), .data_ready(data_ready2), .parity_err(parity_err2),
    .frame_err(frame_err2), .overrun_err(overrun_err2), .break_det(break_det2),
    .busy(busy2), .state_dbg(state_dbg2));

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  // Reference model: what one frame should produce, from the frame rules alone.
  task automatic model_frame(input logic [7:0] word, input logic pbit, input logic stopb);
    logic pe, fe;
    if (word == 8'h00 && !pbit && !stopb) begin
      exp_brk++;
    end else begin
      pe = (pbit != (($countones(word) % 2) == 1));
      fe = !stopb;
      exp_q.push_back({pe, fe, word});
    end
  endtask

  // ---------------- drivers ----------------
  task automatic send_bit(input logic b);
    serial_in = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] word, input logic pbit, input logic stopb);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(word[i]);
    send_bit(pbit);
    send_bit(stopb);
    serial_in = 1'b1;
  endtask

  task automatic send_bit2(input logic b);
    serial_in2 = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    serial_in = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name);
    int k;
    k = 0;
    while (!data_valid && k < 400) begin @(negedge clk); k++; end
    chk(name, {31'd0, data_valid}, 32'd1);
  endtask

  task automatic wait_drain(input string name);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || data_valid) && k < 3000) begin @(negedge clk); k++; end
    chk(name, exp_q.size(), 0);
  endtask

  // Consumer ready: random during the soak, otherwise whatever the scenario commands.
  initial begin
    data_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      data_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_cmd;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!reset) begin
      if (overrun_err) ovr_cnt++;
      if (break_det)   brk_cnt++;
      if (data_valid && data_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", {22'd0, parity_err, frame_err, data_out}, 32'h3ff);
        end else begin
          chk("word", {22'd0, parity_err, frame_err, data_out}, {22'd0, exp_q.pop_front()});
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] w;
    logic pb, sb;
    reset = 1'b1; serial_in = 1'b1; serial_in2 = 1'b1; data_ready2 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {20'd0, data_out, data_valid, parity_err, frame_err,
        overrun_err, break_det, busy}, 32'd0);
    #1 reset = 1'b0;
    idle_cycles(8);

    // 1: 0xA5 good frame, consumer stalls 50 cycles
    ready_cmd = 1'b0;
    model_frame(8'hA5, 1'b0, 1'b1);
    send_frame(8'hA5, 1'b0, 1'b1);
    wait_valid("s1_valid");
    repeat (50) @(posedge clk);
    @(negedge clk);
    chk("s1_held", {21'd0, data_valid, parity_err, frame_err, data_out}, {21'd0, 3'b100, 8'hA5});
    @(posedge clk); #1 ready_cmd = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("s1_drop", {31'd0, data_valid}, 32'd0);

    // 2: wrong parity
    model_frame(8'h01, 1'b0, 1'b1);
    send_frame(8'h01, 1'b0, 1'b1);
    idle_cycles(20);

    // 3: start glitch
    serial_in = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("s3_busy_in_start", {31'd0, busy}, 32'd1);
    @(posedge clk); #1 serial_in = 1'b1;
    repeat (30) @(posedge clk);
    @(negedge clk);
    chk("s3_idle", {30'd0, busy, data_valid}, 32'd0);

    // 4: framing error, then a 12-bit break, then recovery
    #1;
    model_frame(8'h3C, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b0, 1'b0);
    idle_cycles(2 * CPB);
    exp_brk++;
    serial_in = 1'b0;
    repeat (12 * CPB) @(posedge clk);
    @(negedge clk);
    chk("s4_break_pulse", brk_cnt, exp_brk);
    chk("s4_no_word", {31'd0, data_valid}, 32'd0);
    #1 idle_cycles(2 * CPB);
    model_frame(8'h55, 1'b0, 1'b1);
    send_frame(8'h55, 1'b0, 1'b1);
    wait_drain("s4_drain");

    // 5a: back-to-back with consumer stalled -> overrun
    ready_cmd = 1'b0;
    idle_cycles(CPB);
    model_frame(8'h11, 1'b0, 1'b1);
    exp_ovr++;
    send_frame(8'h11, 1'b0, 1'b1);
    send_frame(8'h22, 1'b0, 1'b1);
    idle_cycles(10);
    chk("s5a_overrun", ovr_cnt, exp_ovr);
    chk("s5a_kept", {24'd0, data_out}, 32'h11);
    ready_cmd = 1'b1;
    wait_drain("s5a_drain");

    // 5b: same, ready pulsed exactly on the second frame's completion cycle
    ready_cmd = 1'b0;
    idle_cycles(CPB);
    model_frame(8'h11, 1'b0, 1'b1);
    model_frame(8'h22, 1'b0, 1'b1);
    fork
      begin
        send_frame(8'h11, 1'b0, 1'b1);
        send_frame(8'h22, 1'b0, 1'b1);
      end
      begin
        repeat (FRAME1 + LAT1 - 1) @(posedge clk);
        #1 ready_cmd = 1'b1;
        @(posedge clk);
        #1 ready_cmd = 1'b0;
      end
    join
    idle_cycles(10);
    chk("s5b_no_overrun", ovr_cnt, exp_ovr);
    chk("s5b_loaded", {23'd0, data_valid, data_out}, {23'd0, 1'b1, 8'h22});
    ready_cmd = 1'b1;
    wait_drain("s5b_drain");

    // 6: reset during data bit 3 while an undelivered word is held
    ready_cmd = 1'b0;
    model_frame(8'h96, 1'b0, 1'b1);
    send_frame(8'h96, 1'b0, 1'b1);
    idle_cycles(CPB);
    send_bit(1'b0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    serial_in = 1'b0;
    repeat (CPB / 2) @(posedge clk);
    @(negedge clk);
    chk("s6_pre_reset", {30'd0, data_valid, busy}, 32'd3);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0; serial_in = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("s6_after_reset", {20'd0, data_out, data_valid, parity_err, frame_err,
        overrun_err, break_det, busy}, 32'd0);
    #1 idle_cycles(3 * CPB);
    ready_cmd = 1'b1;
    model_frame(8'h5A, 1'b0, 1'b1);
    send_frame(8'h5A, 1'b0, 1'b1);
    wait_drain("s6_drain");

    // Random soak: random words, occasional bad parity / stop, random ready
    rand_ready = 1'b1;
    for (int n = 0; n < 20; n++) begin
      w  = 8'($urandom_range(0, 255));
      if (n == 7) w = 8'h00;
      pb = ^w;
      if ($urandom_range(0, 3) == 0) pb = ~pb;
      sb = ($urandom_range(0, 9) != 0);
      if (n == 7) begin pb = 1'b0; sb = 1'b0; end
      model_frame(w, pb, sb);
      send_frame(w, pb, sb);
      idle_cycles($urandom_range(2, 20));
    end
    wait_drain("soak_drain");
    rand_ready = 1'b0;
    ready_cmd = 1'b1;

    // Second configuration: 7 data bits, no parity, 2 stop bits
    #1;
    send_bit2(1'b0);
    for (int i = 0; i < 7; i++) send_bit2(1'b1);
    send_bit2(1'b1); send_bit2(1'b1);
    repeat (50) @(posedge clk);
    @(negedge clk);
    chk("cfg2_held", {22'd0, data_valid2, parity_err2, frame_err2, data_out2},
        {22'd0, 3'b100, 7'h7F});
    @(posedge clk); #1 data_ready2 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("cfg2_drop", {31'd0, data_valid2}, 32'd0);

    chk("overrun_total", ovr_cnt, exp_ovr);
    chk("break_total", brk_cnt, exp_brk);
    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
